vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator. It produces hsync and vsync, a display-enable, downscaled pixel coordinates and line/frame strobes from one system clock. It replaces the fixed-constant vertical synchroniser. Both axes run from one counter chain, so H/V alignment is exact by construction. It feeds the pixel-fetch/colour stage, which indexes its frame memory with `hpixel`/`vpixel`.

## Interface
Parameters:
- CLK_DIV, 2, system clocks per pixel tick (≥1; 2 = 25 MHz pixel rate from 50 MHz clk)
- H_SYNC / H_BP / H_ACT / H_FP, 96 / 48 / 640 / 16, horizontal region lengths in pixel ticks
- V_SYNC / V_BP / V_ACT / V_FP, 2 / 33 / 480 / 10, vertical region lengths in lines
- H_SCALE / V_SCALE, 5 / 5, pixel-replication factors; H_ACT and V_ACT must be exact multiples, otherwise elaboration fails
- HP_W / VP_W, 7 / 7, widths of hpixel/vpixel; they must hold H_ACT/H_SCALE−1 and V_ACT/V_SCALE−1
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of the sync pulses (0 = active-low)
- STOP_AT_FRAME, 1, 1 = finish the current frame after enable falls; 0 = stop on the next clk

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run request, sampled on the clk rising edge
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- display_en  out  1  high while both axes are in their active region
- hpixel  out  HP_W  scaled column; 0 outside the active region
- vpixel  out  VP_W  scaled row; 0 outside the active region
- line_start  out  1  one-clk strobe at h_cnt=0
- frame_start  out  1  one-clk strobe at h_cnt=0, v_cnt=0

## Operation
- Internal counters:
  - div_cnt counts 0..CLK_DIV−1; a pixel tick occurs when div_cnt=CLK_DIV−1.
  - h_cnt counts 0..H_TOTAL−1 (H_TOTAL = sum of the four H regions) and advances on a tick.
  - v_cnt counts 0..V_TOTAL−1 and advances when h_cnt wraps.
  - hs_cnt counts 0..H_SCALE−1 and vs_cnt counts 0..V_SCALE−1; these are replication sub-counters. No dividers are used.
- Horizontal regions by h_cnt: sync [0, H_SYNC), back porch, active [H_SYNC+H_BP, +H_ACT), front porch. The vertical regions follow the same pattern on v_cnt.
- hpixel:
  - Increments when hs_cnt wraps inside the H active region.
  - Returns to 0 at the end of H active.
  - Maximum is H_ACT/H_SCALE−1.
- vpixel:
  - Increments when vs_cnt wraps at the end of an active line.
  - Holds across the blanking of that line and returns to 0 after V active.
  - Maximum is V_ACT/V_SCALE−1.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: all counters are 0 and outputs are idle (sync at its inactive level, everything else 0). If enable is high, go to RUN.
  - RUN: counters run. If enable is low and STOP_AT_FRAME=1, go to DRAIN. If enable is low and STOP_AT_FRAME=0, go to IDLE on that edge and zero the counters.
  - DRAIN: counters keep running.
    - If enable is high, return to RUN with no timing disturbance.
    - If the last clk of the frame is reached (v_cnt=V_TOTAL−1, h_cnt=H_TOTAL−1, tick), go to IDLE.
- All outputs are registered and decoded from the next counter state, so they are cycle-aligned with the counters. No output glitches.

## Timing
- Reset values: state IDLE, all counters 0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, display_en=0, hpixel=0, vpixel=0, line_start=0, frame_start=0.
- Edge 0 is the first edge sampling enable=1 in IDLE. After edge 0: counters are (0,0), hsync and vsync are active, and line_start and frame_start are both 1 for exactly 1 clk.
- Default parameters:
  - Line: 800 ticks = 1600 clk.
  - Frame: 525 lines = 840 000 clk.
  - hsync active for 192 clk per line.
  - vsync active for 3200 clk per frame.
  - display_en rises at clk offset 288 within each line of lines 35..514 and stays high for 1280 clk.
- Each hpixel value lasts CLK_DIV·H_SCALE clk (10 by default), covering 128 values per line.
- Each vpixel value lasts V_SCALE lines, covering 96 values per frame.
- Wrap-around:
  - h wrap and v wrap coincide at frame end with no extra idle clk.
  - The next frame_start follows the last frame clk directly.
- Reset asserted mid-frame forces the reset values immediately (asynchronously), independent of the clock. Operation restarts from IDLE.

## Test plan
- Reset/idle: assert reset mid-line, hold enable=0 → all outputs at reset values; hsync=vsync=1 with default polarity; no strobes for 10 000 clk.
- Line/frame timing: enable=1 with defaults → frame_start period 840 000 clk, line_start period 1600 clk, hsync low 192 clk, vsync low 3200 clk, display_en high 1280 clk on exactly 480 lines per frame.
- Scaling: defaults → hpixel steps 0..127 every 10 clk starting at line offset 288; vpixel steps 0..95 every 5 active lines; both are 0 whenever display_en=0.
- Stop modes:
  - STOP_AT_FRAME=1, drop enable at line 100 → timing continues to frame end, IDLE on the following clk, no further frame_start.
  - Re-raise enable during DRAIN → frame_start arrives exactly 840 000 clk after the previous one.
  - STOP_AT_FRAME=0 → idle outputs on the clk after enable is sampled low.
- Non-default parameters:
  - CLK_DIV=1, H 4/4/8/4, V 1/1/4/1, H_SCALE=V_SCALE=2, HSYNC_POL=1 → line 20 clk, frame 140 clk, hsync high 4 clk, hpixel 0..3 each 2 clk, vpixel 0..1.
- Reset mid-operation: assert reset while display_en=1 at hpixel=64 → outputs return to reset values immediately; after release with enable=1, first frame_start on edge 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: one div/h/v counter chain drives sync, display enable,
// replicated pixel coordinates and line/frame strobes, all registered from next-state decode.
module vga_timing_gen #(
   parameter int CLK_DIV       = 2,
   parameter int H_SYNC        = 96,
   parameter int H_BP          = 48,
   parameter int H_ACT         = 640,
   parameter int H_FP          = 16,
   parameter int V_SYNC        = 2,
   parameter int V_BP          = 33,
   parameter int V_ACT         = 480,
   parameter int V_FP          = 10,
   parameter int H_SCALE       = 5,
   parameter int V_SCALE       = 5,
   parameter int HP_W          = 7,
   parameter int VP_W          = 7,
   parameter int HSYNC_POL     = 0,
   parameter int VSYNC_POL     = 0,
   parameter int STOP_AT_FRAME = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   output logic            hsync,
   output logic            vsync,
   output logic            display_en,
   output logic [HP_W-1:0] hpixel,
   output logic [VP_W-1:0] vpixel,
   output logic            line_start,
   output logic            frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int H_W     = $clog2(H_TOTAL + 1);
   localparam int V_W     = $clog2(V_TOTAL + 1);
   localparam int HS_W    = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
   localparam int VS_W    = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0]   H_SYN_END = H_W'(H_SYNC);
   localparam logic [H_W-1:0]   H_ACT_BEG = H_W'(H_SYNC + H_BP);
   localparam logic [H_W-1:0]   H_ACT_END = H_W'(H_SYNC + H_BP + H_ACT);
   localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0]   V_SYN_END = V_W'(V_SYNC);
   localparam logic [V_W-1:0]   V_ACT_BEG = V_W'(V_SYNC + V_BP);
   localparam logic [V_W-1:0]   V_ACT_END = V_W'(V_SYNC + V_BP + V_ACT);
   localparam logic [HS_W-1:0]  HS_LAST   = HS_W'(H_SCALE - 1);
   localparam logic [VS_W-1:0]  VS_LAST   = VS_W'(V_SCALE - 1);
   localparam logic             HS_ON     = (HSYNC_POL != 0);
   localparam logic             VS_ON     = (VSYNC_POL != 0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   generate
      if (CLK_DIV < 1) begin : g_bad_div
         $error("vga_timing_gen: CLK_DIV must be at least 1");
      end
      if ((H_ACT % H_SCALE) != 0 || (V_ACT % V_SCALE) != 0) begin : g_bad_scale
         $error("vga_timing_gen: active lengths must be multiples of the scale factors");
      end
      if ((H_ACT / H_SCALE) > (1 << HP_W) || (V_ACT / V_SCALE) > (1 << VP_W)) begin : g_bad_pw
         $error("vga_timing_gen: HP_W/VP_W too narrow for the scaled coordinates");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [H_W-1:0]   h_q, h_d;
   logic [V_W-1:0]   v_q, v_d;
   logic [HS_W-1:0]  hs_q, hs_d;
   logic [VS_W-1:0]  vs_q, vs_d;
   logic [HP_W-1:0]  hpix_q, hpix_d;
   logic [VP_W-1:0]  vpix_q, vpix_d;

   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             de_q, de_d;
   logic [HP_W-1:0]  hpixel_q, hpixel_d;
   logic [VP_W-1:0]  vpixel_q, vpixel_d;
   logic             line_start_q, line_start_d;
   logic             frame_start_q, frame_start_d;

   logic             tick, line_end, frame_end, advance;
   logic             run_d, h_act_d, v_act_d;

   always_comb begin
      tick      = (div_q == DIV_LAST);
      line_end  = tick && (h_q == H_LAST);
      frame_end = line_end && (v_q == V_LAST);
      state_d   = state_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) begin
               if (STOP_AT_FRAME == 0 || frame_end) state_d = ST_IDLE;
               else                                 state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (enable)         state_d = ST_RUN;
            else if (frame_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counters hold at zero in IDLE, so the first RUN clk is exactly (0,0).
   always_comb begin
      advance = (state_q != ST_IDLE) && (state_d != ST_IDLE);
      div_d   = '0;
      h_d     = '0;
      v_d     = '0;
      hs_d    = '0;
      vs_d    = '0;
      hpix_d  = '0;
      vpix_d  = '0;
      if (advance) begin
         div_d  = tick ? '0 : div_q + DIV_W'(1);
         h_d    = h_q;
         v_d    = v_q;
         hs_d   = hs_q;
         vs_d   = vs_q;
         hpix_d = hpix_q;
         vpix_d = vpix_q;
         if (tick) begin
            h_d = line_end ? '0 : h_q + H_W'(1);
            if (h_d > H_ACT_BEG && h_d < H_ACT_END) begin
               if (hs_q == HS_LAST) begin
                  hs_d   = '0;
                  hpix_d = hpix_q + HP_W'(1);
               end else begin
                  hs_d = hs_q + HS_W'(1);
               end
            end else begin
               hs_d   = '0;
               hpix_d = '0;
            end
         end
         if (line_end) begin
            v_d = frame_end ? '0 : v_q + V_W'(1);
            if (v_d > V_ACT_BEG && v_d < V_ACT_END) begin
               if (vs_q == VS_LAST) begin
                  vs_d   = '0;
                  vpix_d = vpix_q + VP_W'(1);
               end else begin
                  vs_d = vs_q + VS_W'(1);
               end
            end else begin
               vs_d   = '0;
               vpix_d = '0;
            end
         end
      end
   end

   always_comb begin
      run_d         = (state_d != ST_IDLE);
      h_act_d       = (h_d >= H_ACT_BEG) && (h_d < H_ACT_END);
      v_act_d       = (v_d >= V_ACT_BEG) && (v_d < V_ACT_END);
      hsync_d       = (run_d && h_d < H_SYN_END) ? HS_ON : ~HS_ON;
      vsync_d       = (run_d && v_d < V_SYN_END) ? VS_ON : ~VS_ON;
      de_d          = run_d && h_act_d && v_act_d;
      hpixel_d      = de_d ? hpix_d : '0;
      vpixel_d      = de_d ? vpix_d : '0;
      line_start_d  = run_d && (div_d == '0) && (h_d == '0);
      frame_start_d = line_start_d && (v_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         div_q         <= '0;
         h_q           <= '0;
         v_q           <= '0;
         hs_q          <= '0;
         vs_q          <= '0;
         hpix_q        <= '0;
         vpix_q        <= '0;
         hsync_q       <= ~HS_ON;
         vsync_q       <= ~VS_ON;
         de_q          <= 1'b0;
         hpixel_q      <= '0;
         vpixel_q      <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         hpix_q        <= hpix_d;
         vpix_q        <= vpix_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         hpixel_q      <= hpixel_d;
         vpixel_q      <= vpixel_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_en  = de_q;
   assign hpixel      = hpixel_q;
   assign vpixel      = vpixel_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a small-raster instance with CLK_DIV=2 and drain-on-stop, and a
// CLK_DIV=1 instance with immediate stop; expected values worked out by hand.
module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       en_a, en_b;
   logic       hs_a, vs_a, de_a, ls_a, fs_a;
   logic [1:0] hp_a;
   logic [0:0] vp_a;
   logic       hs_b, vs_b, de_b, ls_b, fs_b;
   logic [1:0] hp_b;
   logic [0:0] vp_b;

   int n_chk;
   int n_fail;

   always #5 clk = ~clk;

   // A: 20-tick line x 2 clk = 40 clk, 7 lines = 280 clk per frame.
   vga_timing_gen #(
      .CLK_DIV(2), .H_SYNC(4), .H_BP(4), .H_ACT(8), .H_FP(4),
      .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1), .H_SCALE(2), .V_SCALE(2),
      .HP_W(2), .VP_W(1), .HSYNC_POL(1), .VSYNC_POL(0), .STOP_AT_FRAME(1)
   ) u_dut_a (
      .clk(clk), .reset(reset), .enable(en_a), .hsync(hs_a), .vsync(vs_a),
      .display_en(de_a), .hpixel(hp_a), .vpixel(vp_a),
      .line_start(ls_a), .frame_start(fs_a)
   );

   // B: 20 clk per line, 140 clk per frame, stops on the next clk.
   vga_timing_gen #(
      .CLK_DIV(1), .H_SYNC(4), .H_BP(4), .H_ACT(8), .H_FP(4),
      .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1), .H_SCALE(2), .V_SCALE(2),
      .HP_W(2), .VP_W(1), .HSYNC_POL(1), .VSYNC_POL(0), .STOP_AT_FRAME(0)
   ) u_dut_b (
      .clk(clk), .reset(reset), .enable(en_b), .hsync(hs_b), .vsync(vs_b),
      .display_en(de_b), .hpixel(hp_b), .vpixel(vp_b),
      .line_start(ls_b), .frame_start(fs_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int c_hs, c_vs, c_de, c_ls, c_fs, c_bad, c_tail, first_de;
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      en_a   = 1'b0;
      en_b   = 1'b0;

      repeat (3) step();
      check("rst_hsync_a", hs_a, 0);
      check("rst_vsync_a", vs_a, 1);
      check("rst_de_a", de_a, 0);
      check("rst_hpixel_a", hp_a, 0);
      check("rst_vpixel_a", vp_a, 0);
      check("rst_strobes_a", {ls_a, fs_a}, 0);
      check("rst_hsync_b", hs_b, 0);

      reset = 1'b0;
      c_ls = 0;
      c_hs = 0;
      repeat (50) begin
         step();
         c_ls += (ls_a ? 1 : 0) + (fs_a ? 1 : 0) + (ls_b ? 1 : 0) + (fs_b ? 1 : 0);
         c_hs += (hs_a ? 1 : 0) + (hs_b ? 1 : 0) + (vs_a ? 0 : 1);
      end
      check("idle_strobes", c_ls, 0);
      check("idle_sync", c_hs, 0);

      // Frame 1 on A, offsets n relative to edge 0.
      en_a = 1'b1;
      c_hs = 0; c_vs = 0; c_de = 0; c_ls = 0; c_fs = 0; c_bad = 0; first_de = -1;
      for (int n = 0; n <= 280; n++) begin
         step();
         if (n < 280) begin
            c_hs += hs_a ? 1 : 0;
            c_vs += vs_a ? 0 : 1;
            c_de += de_a ? 1 : 0;
            c_ls += ls_a ? 1 : 0;
            c_fs += fs_a ? 1 : 0;
            if (!de_a && (hp_a != 0 || vp_a != 0)) c_bad++;
            if (de_a && first_de < 0) first_de = n;
         end
         if (n == 0) begin
            check("a_edge0_fs", fs_a, 1);
            check("a_edge0_ls", ls_a, 1);
            check("a_edge0_hsync", hs_a, 1);
            check("a_edge0_vsync", vs_a, 0);
         end
         if (n == 1)   check("a_n1_ls", ls_a, 0);
         if (n == 8)   check("a_hsync_end", hs_a, 0);
         if (n == 40)  check("a_line1_ls", ls_a, 1);
         if (n == 96)  check("a_hp0", hp_a, 0);
         if (n == 100) check("a_hp1", hp_a, 1);
         if (n == 111) check("a_hp3", hp_a, 3);
         if (n == 112) check("a_de_end", de_a, 0);
         if (n == 136) check("a_vp0", vp_a, 0);
         if (n == 176) check("a_vp1", vp_a, 1);
         if (n == 280) check("a_frame_period", fs_a, 1);
      end
      check("a_hsync_clks", c_hs, 56);
      check("a_vsync_clks", c_vs, 40);
      check("a_de_clks", c_de, 64);
      check("a_line_starts", c_ls, 7);
      check("a_frame_starts", c_fs, 1);
      check("a_pix_outside_de", c_bad, 0);
      check("a_first_de", first_de, 96);

      // Frame 2: drop and re-raise enable; frame 3: drop and drain to idle.
      c_fs = 0;
      c_tail = 0;
      for (int n = 281; n <= 900; n++) begin
         step();
         if (n < 560) c_fs += fs_a ? 1 : 0;
         if (n == 560) check("a_reraise_fs", fs_a, 1);
         if (n == 656) check("a_drain_de", de_a, 1);
         if (n == 800) check("a_drain_ls", ls_a, 1);
         if (n == 840) check("a_drain_idle_fs", fs_a, 0);
         if (n >= 840)
            c_tail += (ls_a ? 1 : 0) + (fs_a ? 1 : 0) + (de_a ? 1 : 0) + (hs_a ? 1 : 0) + (vs_a ? 0 : 1);
         if (n == 325 || n == 605) en_a = 1'b0;
         if (n == 380) en_a = 1'b1;
      end
      check("a_drain_no_fs", c_fs, 0);
      check("a_idle_after_drain", c_tail, 0);

      // Restart, then asynchronous reset in the middle of an active span.
      en_a = 1'b1;
      step();
      check("a_restart_fs", fs_a, 1);
      repeat (104) step();
      check("a_pre_rst_de", de_a, 1);
      check("a_pre_rst_hp", hp_a, 2);
      #2 reset = 1'b1;
      #1;
      check("a_async_rst_de", de_a, 0);
      check("a_async_rst_hp", hp_a, 0);
      check("a_async_rst_vsync", vs_a, 1);
      repeat (3) step();
      #2 reset = 1'b0;
      step();
      check("a_post_rst_fs", fs_a, 1);
      check("a_post_rst_hsync", hs_a, 1);
      en_a = 1'b0;

      // B: CLK_DIV=1 timing and immediate stop.
      en_b = 1'b1;
      c_hs = 0; c_ls = 0; c_de = 0; c_tail = 0;
      for (int m = 0; m <= 200; m++) begin
         step();
         if (m < 140) begin
            c_hs += hs_b ? 1 : 0;
            c_ls += ls_b ? 1 : 0;
            c_de += de_b ? 1 : 0;
         end
         if (m == 0)   check("b_edge0_fs", fs_b, 1);
         if (m == 19)  check("b_ls_off", ls_b, 0);
         if (m == 20)  check("b_ls_period", ls_b, 1);
         if (m == 48)  check("b_hp0", hp_b, 0);
         if (m == 50)  check("b_hp1", hp_b, 1);
         if (m == 55)  check("b_hp3", hp_b, 3);
         if (m == 56)  check("b_de_end", de_b, 0);
         if (m == 88)  check("b_vp1", vp_b, 1);
         if (m == 140) check("b_frame_period", fs_b, 1);
         if (m == 189) begin
            check("b_pre_stop_de", de_b, 1);
            en_b = 1'b0;
         end
         if (m == 190) check("b_stop_de", de_b, 0);
         if (m >= 190)
            c_tail += (ls_b ? 1 : 0) + (fs_b ? 1 : 0) + (de_b ? 1 : 0) + (hs_b ? 1 : 0) + (vs_b ? 0 : 1);
      end
      check("b_hsync_clks", c_hs, 28);
      check("b_line_starts", c_ls, 7);
      check("b_de_clks", c_de, 32);
      check("b_idle_after_stop", c_tail, 0);
      en_b = 1'b1;
      step();
      check("b_restart_fs", fs_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
